// File: rtl/fp_mult_seq.sv
// rtl/fp_mult_seq.sv - sequential FP32 multiplier, 24-cycle shift-add core, truncating, fixed 27-cycle latency
module fp_mult_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_PACK
    } state_t;

    state_t state, state_next;

    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [47:0]       mcand_q, prod_q;
    logic [23:0]       mplier_q;
    logic [4:0]        cnt_q;
    logic [22:0]       frac_q;
    logic              special_q;
    logic [31:0]       special_val_q;

    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]       sig_a, sig_b;
    logic signed [9:0] exp_sum;
    logic              sign_ab;
    logic [31:0]       packed_val;

    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign fa      = a_q[22:0];
    assign fb      = b_q[22:0];
    assign sign_ab = a_q[31] ^ b_q[31];
    assign a_zero  = (ea == 8'h00);
    assign b_zero  = (eb == 8'h00);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'h0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'h0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'h0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'h0);
    // Denormals carry no hidden bit and are flushed to zero on entry.
    assign sig_a   = a_zero ? 24'h0 : {1'b1, fa};
    assign sig_b   = b_zero ? 24'h0 : {1'b1, fb};
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    always_comb begin
        packed_val = {sign_q, exp_q[7:0], frac_q};
        if (special_q) begin
            packed_val = special_val_q;
        end else if (exp_q >= 10'sd255) begin
            packed_val = {sign_q, 8'hFF, 23'h0};
        end else if (exp_q <= 10'sd0) begin
            packed_val = {sign_q, 31'h0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) state_next = S_UNPACK;
            S_UNPACK: state_next = S_MULT;
            S_MULT:   if (cnt_q == 5'd23) state_next = S_NORM;
            S_NORM:   state_next = S_PACK;
            S_PACK:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            sign_q        <= 1'b0;
            exp_q         <= 10'sd0;
            mcand_q       <= 48'h0;
            prod_q        <= 48'h0;
            mplier_q      <= 24'h0;
            cnt_q         <= 5'd0;
            frac_q        <= 23'h0;
            special_q     <= 1'b0;
            special_val_q <= 32'h0;
            result        <= 32'h0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= op_a;
                        b_q  <= op_b;
                        done <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    sign_q   <= sign_ab;
                    exp_q    <= exp_sum;
                    mcand_q  <= {24'h0, sig_a};
                    mplier_q <= sig_b;
                    prod_q   <= 48'h0;
                    cnt_q    <= 5'd0;
                    special_q     <= 1'b1;
                    special_val_q <= 32'h0;
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                        special_val_q <= 32'h7FC00000;
                    end else if (a_inf || b_inf) begin
                        special_val_q <= {sign_ab, 8'hFF, 23'h0};
                    end else if (a_zero || b_zero) begin
                        special_val_q <= {sign_ab, 31'h0};
                    end else begin
                        special_q <= 1'b0;
                    end
                end
                S_MULT: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
                end
                S_NORM: begin
                    if (prod_q[47]) begin
                        frac_q <= prod_q[46:24];
                        exp_q  <= exp_q + 10'sd1;
                    end else begin
                        frac_q <= prod_q[45:23];
                    end
                end
                S_PACK: begin
                    result <= packed_val;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// tb/tb_fp_mult_seq.sv - scoreboard bench for fp_mult_seq with directed and random FP32 vectors
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;
    logic [31:0] result;
    logic        busy, done;

    fp_mult_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          edge_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        done_prev = 1'b0;
    logic [31:0] res_prev = 32'h0;
    logic [31:0] m_e;
    int          m_c;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        longint      ma, mb, p;
        logic [22:0] frac;
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return 32'h7FC00000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'h0};
        if (zero_a || zero_b) return {s, 31'h0};
        ma = 0;
        mb = 0;
        ma[23:0] = {1'b1, a[22:0]};
        mb[23:0] = {1'b1, b[22:0]};
        p = ma * mb;
        e = ea + eb - 127;
        if (p >= (64'sd1 <<< 47)) begin
            e    = e + 1;
            frac = 23'(p >>> 24);
        end else begin
            frac = 23'(p >>> 23);
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), frac};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          r;
        v = $urandom;
        r = $urandom_range(0, 9);
        case (r)
            0: v = {v[31], 8'hFF, 23'h0};
            1: v = {v[31], 8'hFF, v[22:1], 1'b1};
            2: v = {v[31], 8'h00, v[22:0]};
            3: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(110, 144));
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (busy && done) begin
            n_err++;
            $display("FAIL busy_done_exclusive: busy=%0b done=%0b, required not both high", busy, done);
        end
        if (busy && (result !== res_prev)) begin
            n_err++;
            $display("FAIL result_stable_while_busy: got %08h, required %08h", result, res_prev);
        end
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done rose at edge %0d with no pending operation", cyc);
            end else begin
                m_e = exp_q.pop_front();
                m_c = edge_q.pop_front();
                n_vec++;
                if (result !== m_e) begin
                    n_err++;
                    $display("FAIL result: got %08h, required %08h", result, m_e);
                end
                n_vec++;
                if (cyc != m_c) begin
                    n_err++;
                    $display("FAIL latency: done at edge %0d, required edge %0d", cyc, m_c);
                end
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_at_done: got %0b, required 0", busy);
                end
            end
        end
        done_prev = done;
        res_prev  = result;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h, required %08h", name, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back(want);
        edge_q.push_back(cyc + 28);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 120) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            edge_q.delete();
        end
    endtask

    logic [31:0] dir_a[11] = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h7F000000,
                               32'h00800000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                               32'h7FC00001, 32'h7F800000, 32'h00000000};
    logic [31:0] dir_b[11] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h7F000000,
                               32'h00800000, 32'h40000000, 32'h00000000, 32'h40000000,
                               32'h3F800000, 32'hFF800000, 32'hC0000000};
    logic [31:0] dir_r[11] = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h7F800000,
                               32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                               32'h7FC00000, 32'hFF800000, 32'h80000000};

    initial begin
        int k, n;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'h0;
        op_b  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done_low", {31'h0, done}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            issue(dir_a[i], dir_b[i], dir_r[i]);
            wait_drain();
        end

        issue(32'h3FC00000, 32'h40000000, 32'h40400000);
        k = edge_q[$] - 27;
        while (cyc < k + 4) @(negedge clk);
        op_a  = 32'h40A00000;
        op_b  = 32'h41200000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        @(negedge clk);
        n     = cyc;
        op_a  = 32'hC0400000;
        op_b  = 32'h3F000000;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hBFC00000);
            edge_q.push_back(n + 28 + 28 * i);
        end
        while (cyc < n + 57) @(negedge clk);
        start = 1'b0;
        wait_drain();

        issue(32'h3FC00000, 32'h40000000, 32'h40400000);
        k = edge_q[$] - 27;
        while (cyc < k + 9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_result", result, 32'h0);
        check("async_reset_busy", {31'h0, busy}, 32'h0);
        check("async_reset_done", {31'h0, done}, 32'h0);
        exp_q.delete();
        edge_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_reset", {30'h0, busy, done}, 32'h0);
        issue(32'hC0400000, 32'h3F000000, 32'hBFC00000);
        wait_drain();

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            issue(ra, rb, model(ra, rb));
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
